// File: rtl/selfcheck_pkg.sv
// Purpose: shared types, constants and expected-result table for the MMIO self-check responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package selfcheck_pkg;

    // Largest number of result slots the responder can be built with.
    localparam int MAX_CHECKS = 16;

    // first_fail_idx value used when the first failure is not tied to a slot:
    // a duplicate write, an out-of-window store, or a timeout.
    localparam logic [4:0] NO_SLOT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // Result of decoding a store/load address against the slot window.
    typedef struct packed {
        logic       in_win;
        logic [3:0] idx;
    } slot_dec_t;

    // Expected results of the branch/upper-immediate directed program.
    // Slots past the program's result count are never in-window.
    function automatic logic [31:0] expected_val(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: v = 32'd1;
            4'd6:                               v = 32'h1234_5000;
            4'd7:                               v = 32'h0001_0078;
            default:                            v = 32'd0;
        endcase
        return v;
    endfunction

    // A byte address hits a slot when its offset from the base is word
    // aligned and the word index is below the slot count. Addresses below
    // the base wrap to a huge offset and therefore fall out of the window.
    function automatic slot_dec_t decode_slot(input logic [31:0] adr,
                                              input logic [31:0] base,
                                              input int          num);
        logic [31:0] off;
        slot_dec_t   d;
        off      = adr - base;
        d.in_win = (off[1:0] == 2'b00) && (off[31:2] < 30'(num));
        d.idx    = off[5:2];
        return d;
    endfunction

endpackage

// File: rtl/sat_counter8.sv
// Purpose: 8-bit event counter that sticks at 255 instead of wrapping.
// Latency: count visible the cycle after the enabled edge.
// Backpressure: none; one increment per cycle at most.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears the count
//   i_inc    increment enable
//   o_count  current count, registered
module sat_counter8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mmio_selfcheck.sv
// Purpose: scores result stores from the core's data-store port against an expected table; exposes verdict/tallies/readback.
// Latency: tallies, verdict and readback all registered, visible the cycle after the store/load edge.
// Backpressure: none; observes one store or load per cycle and never stalls the core.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   memwrite          store strobe, one cycle per store
//   dataadr           store/load byte address
//   writedata         store data
//   readdata          captured slot value for an in-window load, else 0
//   done/pass/fail    verdict (done = PASS or FAIL state)
//   timeout           FAIL was caused by the run timer expiring
//   pass_count        matching first-writes, saturating
//   fail_count        mismatches, duplicates and out-of-window stores, saturating
//   first_fail_idx    slot of the first mismatch, NO_SLOT for other first causes
import selfcheck_pkg::*;

module mmio_selfcheck #(
    parameter logic [31:0] BASE_ADDR      = 32'd200,
    parameter int          NUM_CHECKS     = 8,
    parameter int          TIMEOUT_CYCLES = 280
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [7:0]  pass_count,
    output logic [7:0]  fail_count,
    output logic [4:0]  first_fail_idx
);

    // Slots at or above NUM_CHECKS are never in-window; masking them in lets
    // the completion test be a plain AND across all MAX_CHECKS bits.
    localparam logic [MAX_CHECKS-1:0] CHECK_MASK =
        MAX_CHECKS'((32'd1 << NUM_CHECKS) - 32'd1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_timeout;
    logic                  r_any_fail;
    logic [4:0]            r_ffi;
    logic [MAX_CHECKS-1:0] r_seen;
    logic [31:0]           r_slot [MAX_CHECKS];
    logic [31:0]           r_readdata;
    logic [15:0]           r_timer;

    slot_dec_t             w_dec;
    logic                  w_dup;
    logic                  w_match;
    logic                  w_store_win;
    logic                  w_store_ok;
    logic                  w_store_fail;
    logic [MAX_CHECKS-1:0] w_seen_nxt;
    logic                  w_all_seen;
    logic                  w_t_hit;
    logic                  w_timing;
    logic                  w_to_set;

    // ------------------------------------------------------------------
    // Store classification
    // ------------------------------------------------------------------
    assign w_dec        = decode_slot(dataadr, BASE_ADDR, NUM_CHECKS);
    assign w_dup        = r_seen[w_dec.idx];
    assign w_match      = (writedata == expected_val(w_dec.idx));
    assign w_store_win  = memwrite && w_dec.in_win;
    // Only a first write to a slot with the right value scores as a pass;
    // every other store (mismatch, duplicate, out-of-window) is a failure.
    assign w_store_ok   = w_store_win && !w_dup && w_match;
    assign w_store_fail = memwrite && !w_store_ok;

    assign w_seen_nxt = r_seen |
                        (w_store_win ? (MAX_CHECKS'(1) << w_dec.idx) : '0);
    assign w_all_seen = &(w_seen_nxt | ~CHECK_MASK);

    // The timer only runs while no verdict has been reached.
    assign w_timing = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_t_hit  = w_timing && (r_timer >= TIMEOUT_LIMIT);

    // ------------------------------------------------------------------
    // Verdict FSM
    // ------------------------------------------------------------------
    // Priority on one edge: a failing store beats the timer (FAIL without
    // timeout), and a completing good store beats the timer (PASS).
    always_comb begin
        w_state_nxt = r_state;
        w_to_set    = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_store_fail) begin
                    w_state_nxt = ST_FAIL;
                end else if (w_store_ok && w_all_seen) begin
                    w_state_nxt = ST_PASS;
                end else if (w_t_hit) begin
                    w_state_nxt = ST_FAIL;
                    w_to_set    = 1'b1;
                end else if (memwrite) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_PASS: begin
                if (w_store_fail) begin
                    w_state_nxt = ST_FAIL;
                end
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_FAIL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run timer: counts edges while no verdict, holds at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 16'd0;
        end else if (w_timing && (r_timer != 16'hFFFF)) begin
            r_timer <= r_timer + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // First-failure capture. A timeout also counts as the first failure so
    // that a later mismatch cannot overwrite NO_SLOT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_fail <= 1'b0;
            r_ffi      <= NO_SLOT;
        end else if (!r_any_fail) begin
            if (w_store_fail) begin
                r_any_fail <= 1'b1;
                r_ffi      <= (w_store_win && !w_dup) ? {1'b0, w_dec.idx}
                                                      : NO_SLOT;
            end else if (w_to_set) begin
                r_any_fail <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot capture and readback. Duplicate writes still overwrite the slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen     <= '0;
            r_readdata <= 32'd0;
            for (int i = 0; i < MAX_CHECKS; i++) begin
                r_slot[i] <= 32'd0;
            end
        end else begin
            r_seen <= w_seen_nxt;
            if (w_store_win) begin
                r_slot[w_dec.idx] <= writedata;
            end
            if (!memwrite && w_dec.in_win) begin
                r_readdata <= r_slot[w_dec.idx];
            end else begin
                r_readdata <= 32'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tallies
    // ------------------------------------------------------------------
    sat_counter8 u_pass_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_store_ok),
        .o_count (pass_count)
    );

    sat_counter8 u_fail_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_store_fail),
        .o_count (fail_count)
    );

    assign readdata       = r_readdata;
    assign done           = (r_state == ST_PASS) || (r_state == ST_FAIL);
    assign pass           = (r_state == ST_PASS);
    assign fail           = (r_state == ST_FAIL);
    assign timeout        = r_timeout;
    assign first_fail_idx = r_ffi;

endmodule

// File: tb/tb_mmio_selfcheck.sv
// Purpose: directed self-checking bench for mmio_selfcheck with a queue-based scoreboard.
// Latency: expects every store/load result one cycle after its sampling edge.
// Backpressure: none; the bench drives at most one store or load per cycle.
module tb_mmio_selfcheck;

    localparam logic [31:0] BASE = 32'd200;
    localparam int          TO   = 280;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        done, pass, fail, timeout;
    logic [7:0]  pass_count, fail_count;
    logic [4:0]  first_fail_idx;

    mmio_selfcheck #(
        .BASE_ADDR      (BASE),
        .NUM_CHECKS     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .memwrite       (memwrite),
        .dataadr        (dataadr),
        .writedata      (writedata),
        .readdata       (readdata),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .timeout        (timeout),
        .pass_count     (pass_count),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  fc;
        logic [4:0]  ffi;
        logic        p;
        logic        f;
        logic        d;
        logic        t;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];

    logic [31:0] exp_tbl [8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1,
                                 32'h1234_5000, 32'h0001_0078};

    // Reference model state; m_st: 0 = idle/run, 1 = pass, 2 = fail.
    logic [31:0] m_slot [8];
    bit          m_seen [8];
    int          m_pc, m_fc, m_st;
    logic [4:0]  m_ffi;
    bit          m_any, m_to;

    int n_cmp = 0;
    int n_bad = 0;
    int edges = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_slot[i] = 32'd0;
            m_seen[i] = 1'b0;
        end
        m_pc = 0; m_fc = 0; m_st = 0;
        m_ffi = 5'd31; m_any = 1'b0; m_to = 1'b0;
    endtask

    function automatic exp_t snap(input logic [31:0] rd);
        exp_t e;
        e.pc  = 8'(m_pc);
        e.fc  = 8'(m_fc);
        e.ffi = m_ffi;
        e.p   = (m_st == 1);
        e.f   = (m_st == 2);
        e.d   = (m_st != 0);
        e.t   = m_to;
        e.rd  = rd;
        return e;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        bit          inwin, bad, all;
        int          idx;
        logic [4:0]  cause;
        off   = a - BASE;
        inwin = (off % 4 == 0) && (off / 4 < 8);
        idx   = int'(off / 4);
        bad   = 1'b0;
        cause = 5'd31;
        if (inwin) begin
            if (m_seen[idx]) begin
                bad = 1'b1;
            end else if (d !== exp_tbl[idx]) begin
                bad   = 1'b1;
                cause = 5'(idx);
            end
            m_seen[idx] = 1'b1;
            m_slot[idx] = d;
        end else begin
            bad = 1'b1;
        end
        if (bad) begin
            if (m_fc < 255) m_fc++;
            if (!m_any) begin
                m_ffi = cause;
                m_any = 1'b1;
            end
            m_st = 2;
        end else begin
            if (m_pc < 255) m_pc++;
            all = 1'b1;
            for (int i = 0; i < 8; i++) if (!m_seen[i]) all = 1'b0;
            if (all && m_st != 2) m_st = 1;
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if ((off % 4 == 0) && (off / 4 < 8)) return m_slot[int'(off / 4)];
        return 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "/pass_count"}, pass_count, e.pc);
            check({tag, "/fail_count"}, fail_count, e.fc);
            check({tag, "/first_fail_idx"}, first_fail_idx, e.ffi);
            check({tag, "/pass"}, pass, e.p);
            check({tag, "/fail"}, fail, e.f);
            check({tag, "/done"}, done, e.d);
            check({tag, "/timeout"}, timeout, e.t);
            check({tag, "/readdata"}, readdata, e.rd);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string tag);
        memwrite = 1'b1; dataadr = a; writedata = d;
        model_store(a, d);
        sb.push_back(snap(32'd0));
        tick();
        memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
        compare(tag);
    endtask

    task automatic do_load(input logic [31:0] a, input string tag);
        memwrite = 1'b0; dataadr = a;
        sb.push_back(snap(model_load(a)));
        tick();
        dataadr = 32'd0;
        compare(tag);
    endtask

    task automatic idle();
        memwrite = 1'b0; dataadr = 32'd0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/readdata"}, readdata, 32'd0);
        check({tag, "/done"}, done, 1'b0);
        check({tag, "/pass"}, pass, 1'b0);
        check({tag, "/fail"}, fail, 1'b0);
        check({tag, "/timeout"}, timeout, 1'b0);
        check({tag, "/pass_count"}, pass_count, 8'd0);
        check({tag, "/fail_count"}, fail_count, 8'd0);
        check({tag, "/first_fail_idx"}, first_fail_idx, 5'd31);
    endtask

    // Holds reset across two edges, then releases it 1 time unit after an
    // edge so the following edge is edge 1 of the new run.
    task automatic apply_reset();
        memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        edges = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        apply_reset();
        check_reset_vals("reset");

        // All eight correct, one store every three cycles
        for (int i = 0; i < 8; i++) begin
            do_store(BASE + 32'(4 * i), exp_tbl[i], $sformatf("allok_%0d", i));
            idle();
            idle();
        end
        do_load(32'd224, "load_224");
        do_load(32'd232, "load_oow");
        do_load(32'd203, "load_unaligned");
        // A failing store after PASS still scores and moves to FAIL
        do_store(32'd200, 32'd1, "pass_then_dup");

        // Slot 1 mismatch
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_store(BASE + 32'(4 * i), (i == 1) ? 32'd0 : exp_tbl[i],
                     $sformatf("mis1_%0d", i));
        end

        // Out-of-window store, then a correct store
        apply_reset();
        do_store(32'd232, 32'd1, "oow");
        do_store(32'd200, 32'd1, "oow_then_ok");
        do_store(32'd196, 32'd1, "below_base");

        // Duplicate write
        apply_reset();
        do_store(32'd200, 32'd1, "dup_first");
        do_store(32'd200, 32'd1, "dup_second");
        do_store(32'd228, 32'd5, "dup_then_mis");

        // No stores: timeout on edge TO+1 after release
        apply_reset();
        while (edges < TO) idle();
        check("to_before/timeout", timeout, 1'b0);
        check("to_before/done", done, 1'b0);
        idle();
        m_st = 2; m_to = 1'b1; m_any = 1'b1;
        check("to_hit/timeout", timeout, 1'b1);
        check("to_hit/fail", fail, 1'b1);
        check("to_hit/done", done, 1'b1);
        check("to_hit/pass", pass, 1'b0);
        check("to_hit/pass_count", pass_count, 8'd0);
        check("to_hit/first_fail_idx", first_fail_idx, 5'd31);
        do_store(32'd208, 32'd1, "to_then_ok");
        do_store(32'd212, 32'd9, "to_then_mis");

        // Completing store on the timeout edge wins and passes
        apply_reset();
        for (int i = 0; i < 7; i++) do_store(BASE + 32'(4 * i), exp_tbl[i], $sformatf("race_%0d", i));
        while (edges < TO) idle();
        do_store(32'd228, exp_tbl[7], "race_last");
        repeat (5) idle();
        check("race_hold/pass", pass, 1'b1);
        check("race_hold/timeout", timeout, 1'b0);

        // Failing store on the timeout edge: FAIL without timeout
        apply_reset();
        while (edges < TO) idle();
        do_store(32'd204, 32'd0, "race_fail");

        // Fail counter saturates at 255
        apply_reset();
        for (int i = 0; i < 257; i++) do_store(32'd300, 32'd0, $sformatf("sat_%0d", i));

        // Reset asserted mid-run clears outputs immediately
        apply_reset();
        do_store(32'd200, 32'd1, "mid_a");
        do_store(32'd204, 32'd0, "mid_b");
        do_load(32'd200, "mid_load");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        apply_reset();
        check_reset_vals("after_midrst");
        do_store(32'd200, 32'd1, "after_midrst_store");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
